// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - HI/LO controller op codes, FSM encoding and sizing constants
package hilo_pkg;

    localparam int WIDTH      = 32;
    localparam int DIV_CYCLES = 32;
    localparam int CNT_W      = $clog2(DIV_CYCLES);

    localparam logic [5:0] OP_MULT  = 6'b011011;
    localparam logic [5:0] OP_MULTU = 6'b001011;
    localparam logic [5:0] OP_DIV   = 6'b011100;
    localparam logic [5:0] OP_DIVU  = 6'b001100;
    localparam logic [5:0] OP_MTHI  = 6'b100000;
    localparam logic [5:0] OP_MTLO  = 6'b100001;
    localparam logic [5:0] OP_MFHI  = 6'b100010;
    localparam logic [5:0] OP_MFLO  = 6'b100011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/div_radix2.sv
// rtl/div_radix2.sv - unsigned restoring divider, one quotient bit per cycle
module div_radix2
    import hilo_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic             busy;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] d_r;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             ge;

    // Quotient bits shift in from the bottom while dividend bits shift out the top.
    assign shifted   = {r_r, q_r[WIDTH-1]};
    assign trial     = shifted - {1'b0, d_r};
    assign ge        = ~trial[WIDTH];
    assign remainder = ge ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quotient  = {q_r[WIDTH-2:0], ge};
    assign done      = busy & (count == CNT_W'(DIV_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= 1'b0;
            count <= '0;
            q_r   <= '0;
            r_r   <= '0;
            d_r   <= '0;
        end else if (abort) begin
            busy  <= 1'b0;
            count <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            count <= '0;
            q_r   <= dividend;
            r_r   <= '0;
            d_r   <= divisor;
        end else if (busy) begin
            q_r   <= quotient;
            r_r   <= remainder;
            count <= count + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/hilo_ctrl.sv
// rtl/hilo_ctrl.sv - HI/LO register owner: single-cycle multiply, iterative divide, mt/mf moves
module hilo_ctrl
    import hilo_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [5:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             stall,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_busy
);

    state_t             state;
    state_t             state_next;
    logic               is_sdiv;
    logic               is_div;
    logic               accept;
    logic               fire;
    logic               div_done;
    logic               div_abort;
    logic               div_write;
    logic [WIDTH-1:0]   div_dividend;
    logic [WIDTH-1:0]   div_divisor;
    logic [WIDTH-1:0]   div_q;
    logic [WIDTH-1:0]   div_r;
    logic               neg_q;
    logic               neg_r;
    logic               dbz;
    logic [WIDTH-1:0]   dbz_hi;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_u;

    assign is_sdiv   = (op == OP_DIV);
    assign is_div    = is_sdiv | (op == OP_DIVU);
    assign accept    = (state == ST_IDLE) & valid & ~flush & is_div;
    // DONE is the divide's own retire slot, so nothing else may fire there.
    assign fire      = valid & ~flush & ~stall & (state != ST_DONE);
    assign div_abort = flush & (state == ST_BUSY);
    assign div_write = (state == ST_BUSY) & div_done & ~flush;

    assign div_dividend = neg_if(a, is_sdiv & a[WIDTH-1]);
    assign div_divisor  = neg_if(b, is_sdiv & b[WIDTH-1]);

    // Low 2*WIDTH bits of a product are the same for signed and unsigned once operands are extended.
    assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    div_radix2 u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (accept),
        .abort     (div_abort),
        .dividend  (div_dividend),
        .divisor   (div_divisor),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (accept)        state_next = ST_BUSY;
            ST_BUSY: if (flush)         state_next = ST_IDLE;
                     else if (div_done) state_next = ST_DONE;
            ST_DONE:                    state_next = ST_IDLE;
            default:                    state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        stall    = 1'b0;
        div_busy = 1'b0;
        unique case (state)
            ST_IDLE: stall = accept;
            ST_BUSY: begin
                stall    = 1'b1;
                div_busy = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi     <= '0;
            lo     <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dbz    <= 1'b0;
            dbz_hi <= '0;
        end else begin
            if (accept) begin
                neg_q  <= is_sdiv & (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_r  <= is_sdiv & a[WIDTH-1];
                dbz    <= (b == '0);
                dbz_hi <= a;
            end
            if (div_write) begin
                if (dbz) begin
                    hi <= dbz_hi;
                    lo <= '1;
                end else begin
                    hi <= neg_if(div_r, neg_r);
                    lo <= neg_if(div_q, neg_q);
                end
            end else if (fire) begin
                case (op)
                    OP_MULT:  {hi, lo} <= prod_s;
                    OP_MULTU: {hi, lo} <= prod_u;
                    OP_MTHI:  hi <= a;
                    OP_MTLO:  lo <= a;
                    default:  ;
                endcase
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (op)
            OP_MFHI: rd_data = hi;
            OP_MFLO: rd_data = lo;
            default: rd_data = '0;
        endcase
    end

endmodule
